// File: rtl/msi_arbiter_wb.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS master ports share one slave port.
// A master keeps the slave for as long as its cyc stays high.
module msi_arbiter_wb #(
   parameter int NUM_MASTERS = 5,
   parameter int AW          = 32,
   parameter int DW          = 32
) (
   input  logic                      wb_clk,
   input  logic                      wb_rst,
   input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
   input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
   input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]    wbm_we_i,
   input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
   input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
   input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
   output logic [NUM_MASTERS*DW-1:0] wbm_dat_o,
   output logic [NUM_MASTERS-1:0]    wbm_ack_o,
   output logic [NUM_MASTERS-1:0]    wbm_err_o,
   output logic [NUM_MASTERS-1:0]    wbm_rty_o,
   output logic [AW-1:0]             wbs_adr_o,
   output logic [DW-1:0]             wbs_dat_o,
   output logic [DW/8-1:0]           wbs_sel_o,
   output logic                      wbs_we_o,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic [2:0]                wbs_cti_o,
   output logic [1:0]                wbs_bte_o,
   input  logic [DW-1:0]             wbs_dat_i,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i
);

   localparam int SW = DW / 8;
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0] r_grant;
   logic [IW-1:0]          r_last;
   logic [NUM_MASTERS-1:0] w_nextGrant;
   logic [IW-1:0]          w_nextLast;
   logic                   w_found;
   logic                   w_ownerActive;
   logic                   w_stb;

   assign w_ownerActive = |(r_grant & wbm_cyc_i);

   // Round-robin search: first masters above r_last, then wrap around from 0.
   always_comb begin
      w_nextGrant = r_grant;
      w_nextLast  = r_last;
      w_found     = 1'b0;
      if (!w_ownerActive) begin
         w_nextGrant = '0;
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && wbm_cyc_i[i] && (i > int'(r_last))) begin
               w_found        = 1'b1;
               w_nextGrant[i] = 1'b1;
               w_nextLast     = IW'(i);
            end
         end
         for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && wbm_cyc_i[i]) begin
               w_found        = 1'b1;
               w_nextGrant[i] = 1'b1;
               w_nextLast     = IW'(i);
            end
         end
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         r_grant <= '0;
         r_last  <= IW'(NUM_MASTERS - 1);
      end else begin
         r_grant <= w_nextGrant;
         r_last  <= w_nextLast;
      end
   end

   // Grant is one-hot or zero, so an AND-OR mux yields all zeros when idle.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      w_stb     = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_grant[i]) begin
            wbs_adr_o = wbs_adr_o | wbm_adr_i[i*AW +: AW];
            wbs_dat_o = wbs_dat_o | wbm_dat_i[i*DW +: DW];
            wbs_sel_o = wbs_sel_o | wbm_sel_i[i*SW +: SW];
            wbs_we_o  = wbs_we_o  | wbm_we_i[i];
            wbs_cti_o = wbs_cti_o | wbm_cti_i[i*3 +: 3];
            wbs_bte_o = wbs_bte_o | wbm_bte_i[i*2 +: 2];
            w_stb     = w_stb     | wbm_stb_i[i];
         end
      end
   end

   assign wbs_cyc_o = w_ownerActive;
   assign wbs_stb_o = w_stb & w_ownerActive;

   assign wbm_ack_o = {NUM_MASTERS{wbs_ack_i}} & r_grant;
   assign wbm_err_o = {NUM_MASTERS{wbs_err_i}} & r_grant;
   assign wbm_rty_o = {NUM_MASTERS{wbs_rty_i}} & r_grant;
   assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

endmodule

// File: tb/tb_msi_arbiter_wb.sv
// Bench for msi_arbiter_wb: an owner/round-robin model plus a memory slave,
// driven by directed transfers and a five-master soak.
module tb_msi_arbiter_wb;

   localparam int N  = 5;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int BUDGET = 64;
   localparam int SOAK = 1000;

   logic wb_clk = 1'b0;
   logic wb_rst = 1'b1;

   logic [AW-1:0] mAdr [N];
   logic [DW-1:0] mDat [N];
   logic [SW-1:0] mSel [N];
   logic [2:0]    mCti [N];
   logic [1:0]    mBte [N];
   logic [N-1:0]  mWe, mCyc, mStb;

   logic [N*AW-1:0] wbm_adr_i;
   logic [N*DW-1:0] wbm_dat_i;
   logic [N*SW-1:0] wbm_sel_i;
   logic [N*3-1:0]  wbm_cti_i;
   logic [N*2-1:0]  wbm_bte_i;
   logic [N*DW-1:0] wbm_dat_o;
   logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [DW-1:0]   mDatO [N];

   logic [AW-1:0] wbs_adr_o;
   logic [DW-1:0] wbs_dat_o;
   logic [SW-1:0] wbs_sel_o;
   logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [2:0]    wbs_cti_o;
   logic [1:0]    wbs_bte_o;

   logic          sAck, sErr, sRty;
   logic [DW-1:0] sDat;
   bit            slaveMute;
   logic [31:0]   mem    [0:2047];
   logic [31:0]   shadow [0:2047];

   int tests = 0;
   int fails = 0;
   int orderQ [$];
   int owner = -1;
   int lastM = N - 1;

   for (genvar g = 0; g < N; g++) begin : gPack
      assign wbm_adr_i[g*AW +: AW] = mAdr[g];
      assign wbm_dat_i[g*DW +: DW] = mDat[g];
      assign wbm_sel_i[g*SW +: SW] = mSel[g];
      assign wbm_cti_i[g*3 +: 3]   = mCti[g];
      assign wbm_bte_i[g*2 +: 2]   = mBte[g];
      assign mDatO[g]              = wbm_dat_o[g*DW +: DW];
   end

   msi_arbiter_wb #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
      .wbm_we_i(mWe), .wbm_cyc_i(mCyc), .wbm_stb_i(mStb),
      .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
      .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
      .wbm_rty_o(wbm_rty_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
      .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
      .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
      .wbs_dat_i(sDat), .wbs_ack_i(sAck), .wbs_err_i(sErr), .wbs_rty_i(sRty)
   );

   always #5 wb_clk = ~wb_clk;

   function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                              input logic [31:0] nw,
                                              input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // Memory slave: one ack per strobe, registered, unless muted for err/rty tests.
   always @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         sAck <= 1'b0;
         sDat <= '0;
         for (int i = 0; i < 2048; i++) mem[i] <= '0;
      end else if (wbs_cyc_o && wbs_stb_o && !sAck && !slaveMute) begin
         sAck <= 1'b1;
         sDat <= mem[wbs_adr_o[12:2]];
         if (wbs_we_o)
            mem[wbs_adr_o[12:2]] <= mergeBytes(mem[wbs_adr_o[12:2]], wbs_dat_o, wbs_sel_o);
      end else begin
         sAck <= 1'b0;
      end
   end

   // Owner model: the bus belongs to one master until it lowers cyc, then the
   // next requester counting upward (mod N) from the previous owner takes it.
   always @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         owner = -1;
         lastM = N - 1;
      end else if (owner < 0 || !mCyc[owner]) begin
         owner = -1;
         for (int k = 1; k <= N; k++)
            if (owner < 0 && mCyc[(lastM + k) % N]) owner = (lastM + k) % N;
         if (owner >= 0) lastM = owner;
      end
   end

   task automatic checkOutput(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compareLoop();
      logic [AW-1:0] eAdr;
      logic [DW-1:0] eDat;
      logic [SW-1:0] eSel;
      logic [2:0]    eCti;
      logic [1:0]    eBte;
      logic          eWe, eCyc, eStb;
      logic [N-1:0]  eAck, eErr, eRty;
      forever begin
         @(negedge wb_clk);
         eAdr = '0; eDat = '0; eSel = '0; eCti = '0; eBte = '0;
         eWe = 1'b0; eCyc = 1'b0; eStb = 1'b0;
         eAck = '0; eErr = '0; eRty = '0;
         if (owner >= 0) begin
            eAdr = mAdr[owner]; eDat = mDat[owner]; eSel = mSel[owner];
            eCti = mCti[owner]; eBte = mBte[owner]; eWe = mWe[owner];
            eCyc = mCyc[owner];
            eStb = mCyc[owner] & mStb[owner];
            eAck[owner] = sAck;
            eErr[owner] = sErr;
            eRty[owner] = sRty;
         end
         checkOutput("req_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_sel_o},
                     {eCyc, eStb, eWe, eCti, eBte, eSel});
         checkOutput("req_adr", wbs_adr_o, eAdr);
         checkOutput("req_wdat", wbs_dat_o, eDat);
         checkOutput("resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, {eAck, eErr, eRty});
         checkOutput("rdat_bcast", wbm_dat_o, {N{sDat}});
      end
   endtask

   task automatic applyReset();
      wb_rst = 1'b0;
      repeat (2) @(posedge wb_clk);
      @(negedge wb_clk);
      #2 wb_rst = 1'b1;
      @(posedge wb_clk);
      #1;
   endtask

   // Single-beat master transaction; entered and left just after a rising edge.
   task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] adr,
                                input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                                output logic [DW-1:0] rdata, output logic ok,
                                output logic [N-1:0] ackVec);
      mAdr[m] = adr; mDat[m] = dat; mSel[m] = sel; mWe[m] = we;
      mCti[m] = 3'b000; mBte[m] = 2'b00;
      mCyc[m] = 1'b1; mStb[m] = 1'b1;
      ok = 1'b0; rdata = '0; ackVec = '0;
      for (int c = 0; c < BUDGET; c++) begin
         @(negedge wb_clk);
         if (wbm_ack_o[m]) begin
            ok = 1'b1;
            rdata = mDatO[m];
            ackVec = wbm_ack_o;
            break;
         end
      end
      @(posedge wb_clk);
      #1;
      mCyc[m] = 1'b0; mStb[m] = 1'b0; mWe[m] = 1'b0;
   endtask

   task automatic rrOne(input int m);
      logic [DW-1:0] rd;
      logic ok;
      logic [N-1:0] av;
      applyStimulus(m, 1'b0, AW'(m * 1024), '0, 4'hF, rd, ok, av);
      checkOutput("rr_done", ok, 1'b1);
      if (ok) orderQ.push_back(m);
   endtask

   task automatic soakMaster(input int m);
      logic [DW-1:0] rd, dat;
      logic ok, we;
      logic [N-1:0] av;
      logic [SW-1:0] sel;
      int w, idx, done;
      done = 0;
      for (int t = 0; t < SOAK; t++) begin
         w   = $urandom_range(0, 15);
         we  = 1'($urandom_range(0, 1));
         dat = $urandom;
         sel = SW'($urandom_range(1, 15));
         idx = m * 256 + w;
         applyStimulus(m, we, AW'(m * 1024 + w * 4), dat, sel, rd, ok, av);
         checkOutput("soak_nostarve", ok, 1'b1);
         if (ok) begin
            done++;
            if (we) shadow[idx] = mergeBytes(shadow[idx], dat, sel);
            else    checkOutput("soak_read", rd, shadow[idx]);
         end
         repeat ($urandom_range(1, 2)) @(posedge wb_clk);
         #1;
      end
      checkOutput("soak_count", done, SOAK);
   endtask

   initial begin
      #20_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      logic ok;
      logic [N-1:0] av;
      logic [31:0] ord;
      int beats, m3Early;
      logic [AW-1:0] bAdr [4];

      for (int i = 0; i < N; i++) begin
         mAdr[i] = '0; mDat[i] = '0; mSel[i] = '0; mCti[i] = '0; mBte[i] = '0;
      end
      mWe = '0; mCyc = '0; mStb = '0;
      sErr = 1'b0; sRty = 1'b0; slaveMute = 1'b0;
      #1;
      fork compareLoop(); join_none
      applyReset();
      checkOutput("reset_state", {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbs_adr_o}, '0);

      // Master 2 single write: slave side one cycle after cyc, ack only to 2.
      mAdr[2] = 32'h200; mDat[2] = 32'hA5A5A5A5; mSel[2] = 4'hF; mWe[2] = 1'b1;
      mCyc[2] = 1'b1; mStb[2] = 1'b1;
      @(negedge wb_clk);
      checkOutput("grant_latency_pre", wbs_cyc_o, 1'b0);
      @(negedge wb_clk);
      checkOutput("m2_slave_req", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o},
                  {1'b1, 1'b1, 1'b1, 4'hF, 32'h200, 32'hA5A5A5A5});
      @(negedge wb_clk);
      checkOutput("m2_ack_only", wbm_ack_o, 5'b00100);
      @(posedge wb_clk); #1;
      mCyc[2] = 1'b0; mStb[2] = 1'b0; mWe[2] = 1'b0;
      @(posedge wb_clk); #1;
      applyStimulus(2, 1'b0, 32'h200, '0, 4'hF, rd, ok, av);
      checkOutput("m2_read_data", rd, 32'hA5A5A5A5);
      checkOutput("m2_read_ack", av, 5'b00100);

      // Round-robin from reset, then master 0 wins again over master 1.
      applyReset();
      orderQ.delete();
      fork rrOne(0); rrOne(1); rrOne(2); rrOne(3); rrOne(4); join
      fork rrOne(1); rrOne(0); join
      ord = '0;
      for (int i = 0; i < 7; i++)
         ord = (ord << 4) | ((i < orderQ.size()) ? 32'(orderQ[i]) : 32'hF);
      checkOutput("rr_order", ord, 32'h0123401);

      // Burst hold: master 1 keeps the bus for 4 beats while master 3 waits.
      @(posedge wb_clk); #1;
      m3Early = 0;
      beats = 0;
      fork
         begin
            mAdr[1] = 32'h400; mDat[1] = 32'h11110000; mSel[1] = 4'hF; mWe[1] = 1'b1;
            mCti[1] = 3'b010; mCyc[1] = 1'b1; mStb[1] = 1'b1;
            for (int c = 0; c < 100 && beats < 4; c++) begin
               @(negedge wb_clk);
               if (wbm_ack_o[3]) m3Early++;
               if (wbm_ack_o[1]) begin
                  bAdr[beats] = wbs_adr_o;
                  beats++;
                  if (beats < 4) begin
                     @(posedge wb_clk); #1;
                     mAdr[1] = mAdr[1] + 32'd4;
                     mDat[1] = mDat[1] + 32'd1;
                     mCti[1] = (beats == 3) ? 3'b111 : 3'b010;
                  end
               end
            end
            @(posedge wb_clk); #1;
            mCyc[1] = 1'b0; mStb[1] = 1'b0; mWe[1] = 1'b0; mCti[1] = 3'b000;
            @(negedge wb_clk);
            @(negedge wb_clk);
            checkOutput("handover_m3", {wbs_cyc_o, wbs_adr_o}, {1'b1, 32'hC00});
         end
         begin
            logic [DW-1:0] rd3;
            logic ok3;
            logic [N-1:0] av3;
            repeat (2) @(posedge wb_clk);
            #1;
            applyStimulus(3, 1'b0, 32'hC00, '0, 4'hF, rd3, ok3, av3);
            checkOutput("m3_after_burst", {ok3, av3}, {1'b1, 5'b01000});
         end
      join
      checkOutput("burst_beats", beats, 4);
      checkOutput("burst_adr", {bAdr[0], bAdr[1], bAdr[2], bAdr[3]},
                  {32'h400, 32'h404, 32'h408, 32'h40C});
      checkOutput("m3_no_early_ack", m3Early, 0);

      // Error then retry during master 4's cycle reach only master 4.
      @(posedge wb_clk); #1;
      slaveMute = 1'b1;
      mAdr[4] = 32'h1000; mWe[4] = 1'b0; mSel[4] = 4'hF; mCyc[4] = 1'b1; mStb[4] = 1'b1;
      repeat (2) @(posedge wb_clk);
      #1 sErr = 1'b1;
      @(negedge wb_clk);
      checkOutput("err_iso", {wbm_err_o, wbm_rty_o, wbm_ack_o}, {5'b10000, 5'b00000, 5'b00000});
      @(posedge wb_clk);
      #1 sErr = 1'b0; sRty = 1'b1;
      @(negedge wb_clk);
      checkOutput("rty_iso", {wbm_err_o, wbm_rty_o, wbm_ack_o}, {5'b00000, 5'b10000, 5'b00000});
      @(posedge wb_clk);
      #1 sRty = 1'b0; mCyc[4] = 1'b0; mStb[4] = 1'b0; slaveMute = 1'b0;
      @(posedge wb_clk); #1;

      // Reset in the middle of master 0's burst.
      mAdr[0] = 32'h100; mWe[0] = 1'b0; mSel[0] = 4'hF; mCti[0] = 3'b010;
      mCyc[0] = 1'b1; mStb[0] = 1'b1;
      av = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge wb_clk);
         if (wbm_ack_o[0]) begin
            av = wbm_ack_o;
            break;
         end
      end
      checkOutput("rst_pre_ack", av, 5'b00001);
      #2 wb_rst = 1'b0;
      mAdr[3] = 32'hC04; mCyc[3] = 1'b1; mStb[3] = 1'b1;
      #1;
      checkOutput("rst_req_clear", {wbs_cyc_o, wbs_stb_o}, 2'b00);
      checkOutput("rst_resp_clear", {wbm_ack_o, wbm_err_o, wbm_rty_o}, '0);
      @(negedge wb_clk);
      #2 wb_rst = 1'b1;
      @(negedge wb_clk);
      checkOutput("rst_regrant_m0", {wbs_cyc_o, wbs_adr_o}, {1'b1, 32'h100});
      @(posedge wb_clk); #1;
      mCyc[0] = 1'b0; mStb[0] = 1'b0; mCti[0] = 3'b000;
      mCyc[3] = 1'b0; mStb[3] = 1'b0;

      // Soak: all masters hammer disjoint regions concurrently.
      applyReset();
      for (int i = 0; i < 2048; i++) shadow[i] = '0;
      fork soakMaster(0); soakMaster(1); soakMaster(2); soakMaster(3); soakMaster(4); join

      repeat (2) @(posedge wb_clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
